// File: rtl/cvxif_issue_initiator.sv
// Core-side CV-X-IF issue/result initiator: one in-flight issue, ID table, writeback return.
// Optional result watchdog enabled by defining CVXIF_RESULT_TIMEOUT_EN.
module cvxif_issue_initiator #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_instr_i,
  input  logic [3*XLEN-1:0]     req_rs_i,
  output logic                  rej_valid_o,
  output logic [31:0]           rej_instr_o,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [31:0]           x_issue_instr_o,
  output logic [3*XLEN-1:0]     x_issue_rs_o,
  output logic [ID_WIDTH-1:0]   x_issue_id_o,
  input  logic                  x_issue_accept_i,
  input  logic                  x_issue_writeback_i,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [ID_WIDTH-1:0]   x_result_id_i,
  input  logic [XLEN-1:0]       x_result_data_i,
  input  logic [4:0]            x_result_rd_i,
  input  logic                  x_result_we_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  err_o,
  output logic                  timeout_o,
  output logic [ID_WIDTH:0]     outstanding_o
);

  localparam int unsigned NB_ID = 1 << ID_WIDTH;
  localparam int unsigned CNT_W = ID_WIDTH + 1;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [3*XLEN-1:0]     rs_q, rs_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [NB_ID-1:0]      alloc_q, alloc_d;
  logic [NB_ID-1:0]      wbit_q, wbit_d;
  logic                  req_ready_q, req_ready_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  res_ready_q;
  logic                  rej_valid_q, rej_valid_d;
  logic [31:0]           rej_instr_q, rej_instr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;

  logic                  free_found_c;
  logic [ID_WIDTH-1:0]   free_id_c;
  logic                  res_fire_c;
  logic                  res_hit_c;
  logic                  to_hit_c;
  logic [ID_WIDTH-1:0]   to_id_c;

  assign res_fire_c = x_result_valid_i && res_ready_q;
  assign res_hit_c  = res_fire_c && alloc_q[x_result_id_i];

  // Lowest-index free ID, taken from the table as it stood at the start of the cycle.
  always_comb begin
    free_found_c = 1'b0;
    free_id_c    = '0;
    for (int unsigned i = 0; i < NB_ID; i++) begin
      if (!free_found_c && !alloc_q[i]) begin
        free_found_c = 1'b1;
        free_id_c    = ID_WIDTH'(i);
      end
    end
  end

`ifdef CVXIF_RESULT_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0] age_q [NB_ID];

  // Age saturates at the limit so an expired ID waits its turn behind lower expired IDs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NB_ID; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_ID; i++) begin
        if (!alloc_q[i]) begin
          age_q[i] <= '0;
        end else if (age_q[i] != AGE_W'(TIMEOUT_CYCLES - 1)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // A result arriving in the expiry cycle wins over the watchdog for that ID.
  always_comb begin
    to_hit_c = 1'b0;
    to_id_c  = '0;
    for (int unsigned i = 0; i < NB_ID; i++) begin
      if (!to_hit_c && alloc_q[i] && age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1) &&
          !(res_hit_c && x_result_id_i == ID_WIDTH'(i))) begin
        to_hit_c = 1'b1;
        to_id_c  = ID_WIDTH'(i);
      end
    end
  end
`else
  assign to_hit_c = 1'b0;
  assign to_id_c  = '0;
`endif

  // Next-state, table update and registered output values.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rs_d          = rs_q;
    id_d          = id_q;
    alloc_d       = alloc_q;
    wbit_d        = wbit_q;
    rej_valid_d   = 1'b0;
    rej_instr_d   = rej_instr_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    err_d         = 1'b0;
    timeout_d     = 1'b0;
    outstanding_d = '0;

    if (res_fire_c) begin
      if (res_hit_c) begin
        alloc_d[x_result_id_i] = 1'b0;
        if (wbit_q[x_result_id_i] && x_result_we_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = x_result_rd_i;
          wb_data_d  = x_result_data_i;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (to_hit_c) begin
      alloc_d[to_id_c] = 1'b0;
      timeout_d        = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          instr_d = req_instr_i;
          rs_d    = req_rs_i;
          id_d    = free_id_c;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (x_issue_ready_i) begin
          state_d = IDLE;
          if (x_issue_accept_i) begin
            alloc_d[id_q] = 1'b1;
            wbit_d[id_q]  = x_issue_writeback_i;
          end else begin
            rej_valid_d = 1'b1;
            rej_instr_d = instr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NB_ID; i++) begin
      outstanding_d = outstanding_d + CNT_W'(alloc_d[i]);
    end
    req_ready_d   = (state_d == IDLE) && !(&alloc_d);
    issue_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      rs_q          <= '0;
      id_q          <= '0;
      alloc_q       <= '0;
      wbit_q        <= '0;
      req_ready_q   <= 1'b0;
      issue_valid_q <= 1'b0;
      res_ready_q   <= 1'b0;
      rej_valid_q   <= 1'b0;
      rej_instr_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      rs_q          <= rs_d;
      id_q          <= id_d;
      alloc_q       <= alloc_d;
      wbit_q        <= wbit_d;
      req_ready_q   <= req_ready_d;
      issue_valid_q <= issue_valid_d;
      res_ready_q   <= 1'b1;
      rej_valid_q   <= rej_valid_d;
      rej_instr_q   <= rej_instr_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign x_issue_valid_o  = issue_valid_q;
  assign x_issue_instr_o  = instr_q;
  assign x_issue_rs_o     = rs_q;
  assign x_issue_id_o     = id_q;
  assign x_result_ready_o = res_ready_q;
  assign rej_valid_o      = rej_valid_q;
  assign rej_instr_o      = rej_instr_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign err_o            = err_q;
  assign timeout_o        = timeout_q;
  assign outstanding_o    = outstanding_q;

endmodule

// File: tb/tb_cvxif_issue_initiator.sv
// Bench for cvxif_issue_initiator: directed scenarios plus random traffic against a
// transaction-level model of the ID table and pulse outputs.
module tb_cvxif_issue_initiator;
  localparam int unsigned XLEN = 32;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NB   = 4;
  localparam int unsigned TO   = 8;

  logic clk = 1'b0;
  logic rst_ni;
  logic req_valid_i, req_ready_o;
  logic [31:0] req_instr_i;
  logic [3*XLEN-1:0] req_rs_i;
  logic rej_valid_o;
  logic [31:0] rej_instr_o;
  logic x_issue_valid_o, x_issue_ready_i;
  logic [31:0] x_issue_instr_o;
  logic [3*XLEN-1:0] x_issue_rs_o;
  logic [IDW-1:0] x_issue_id_o;
  logic x_issue_accept_i, x_issue_writeback_i;
  logic x_result_valid_i, x_result_ready_o;
  logic [IDW-1:0] x_result_id_i;
  logic [XLEN-1:0] x_result_data_i;
  logic [4:0] x_result_rd_i;
  logic x_result_we_i;
  logic wb_valid_o;
  logic [4:0] wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic err_o, timeout_o;
  logic [IDW:0] outstanding_o;

  cvxif_issue_initiator #(.XLEN(XLEN), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_instr_i(req_instr_i), .req_rs_i(req_rs_i),
    .rej_valid_o(rej_valid_o), .rej_instr_o(rej_instr_o),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_rs_o(x_issue_rs_o),
    .x_issue_id_o(x_issue_id_o), .x_issue_accept_i(x_issue_accept_i),
    .x_issue_writeback_i(x_issue_writeback_i),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .err_o(err_o), .timeout_o(timeout_o), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: pending issue, allocated-ID set with writeback bits, ages, expected pulses.
  bit          m_live, m_pend;
  logic [31:0] m_instr;
  logic [95:0] m_rs;
  int          m_id;
  bit          m_alloc [NB];
  bit          m_wb    [NB];
  int          m_age   [NB];
  bit          e_rej, e_wb, e_err, e_to;
  logic [31:0] e_rej_instr, e_data;
  logic [4:0]  e_rd;

  function automatic int n_alloc();
    int n = 0;
    for (int i = 0; i < NB; i++) n += int'(m_alloc[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NB; i++) if (!m_alloc[i]) return i;
    return -1;
  endfunction

  function automatic bit exp_ready();
    return m_live && !m_pend && (lowest_free() >= 0);
  endfunction

  task automatic model_reset();
    m_live = 0; m_pend = 0; m_id = 0;
    e_rej = 0; e_wb = 0; e_err = 0; e_to = 0;
    for (int i = 0; i < NB; i++) begin
      m_alloc[i] = 0; m_wb[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_update();
    bit rdy = exp_ready();
    int lf  = lowest_free();
    bit freed [NB];
    for (int i = 0; i < NB; i++) freed[i] = 0;
    e_rej = 0; e_wb = 0; e_err = 0; e_to = 0;
    if (x_result_valid_i && m_live) begin
      if (m_alloc[x_result_id_i]) begin
        m_alloc[x_result_id_i] = 0;
        freed[x_result_id_i] = 1;
        if (m_wb[x_result_id_i] && x_result_we_i) begin
          e_wb = 1; e_rd = x_result_rd_i; e_data = x_result_data_i;
        end
      end else begin
        e_err = 1;
      end
    end
`ifdef CVXIF_RESULT_TIMEOUT_EN
    for (int i = 0; i < NB; i++)
      if (m_alloc[i] && !freed[i]) m_age[i] = (m_age[i] + 1 > TO) ? TO : m_age[i] + 1;
    for (int i = 0; i < NB; i++)
      if (!e_to && m_alloc[i] && m_age[i] >= TO) begin
        m_alloc[i] = 0; e_to = 1;
      end
`endif
    if (m_pend && x_issue_ready_i) begin
      if (x_issue_accept_i) begin
        m_alloc[m_id] = 1; m_wb[m_id] = x_issue_writeback_i; m_age[m_id] = 0;
      end else begin
        e_rej = 1; e_rej_instr = m_instr;
      end
      m_pend = 0;
    end else if (req_valid_i && rdy) begin
      m_pend = 1; m_instr = req_instr_i; m_rs = req_rs_i; m_id = lf;
    end
    m_live = 1;
  endtask

  task automatic check_outputs();
    check("req_ready", req_ready_o, exp_ready());
    check("issue_valid", x_issue_valid_o, m_pend);
    if (m_pend) begin
      check("issue_instr", x_issue_instr_o, m_instr);
      check("issue_rs", x_issue_rs_o, m_rs);
      check("issue_id", x_issue_id_o, m_id);
    end
    check("result_ready", x_result_ready_o, m_live);
    check("outstanding", outstanding_o, n_alloc());
    check("rej_valid", rej_valid_o, e_rej);
    if (e_rej) check("rej_instr", rej_instr_o, e_rej_instr);
    check("wb_valid", wb_valid_o, e_wb);
    if (e_wb) begin
      check("wb_rd", wb_rd_o, e_rd);
      check("wb_data", wb_data_o, e_data);
    end
    check("err", err_o, e_err);
    check("timeout", timeout_o, e_to);
  endtask

  task automatic clr_in();
    req_valid_i = 0; req_instr_i = '0; req_rs_i = '0;
    x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
    x_result_valid_i = 0; x_result_id_i = '0; x_result_data_i = '0;
    x_result_rd_i = '0; x_result_we_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic put_req(input logic [31:0] instr, input logic [95:0] rs);
    clr_in(); req_valid_i = 1; req_instr_i = instr; req_rs_i = rs;
    tick();
  endtask

  task automatic put_resp(input bit acc, input bit wb);
    clr_in(); x_issue_ready_i = 1; x_issue_accept_i = acc; x_issue_writeback_i = wb;
    tick();
  endtask

  task automatic put_result(input int id, input logic [4:0] rd, input logic [31:0] data, input bit we);
    clr_in(); x_result_valid_i = 1; x_result_id_i = IDW'(id);
    x_result_rd_i = rd; x_result_data_i = data; x_result_we_i = we;
    tick();
  endtask

  initial begin
    model_reset();
    clr_in();
    rst_ni = 0;
    @(negedge clk);
    check_outputs();
    rst_ni = 1;
    tick();

    // Accepted ROR64H, response on the third cycle, result returned with writeback.
    put_req(32'h00C5_850B, {32'h0, 32'h9ABC_DEF0, 32'h1234_5678});
    check("ror_id", x_issue_id_o, 0);
    clr_in(); tick();
    put_resp(1, 1);
    check("ror_out1", outstanding_o, 1);
    put_result(0, 5'd10, 32'hDEAD_BEEF, 1);
    check("ror_wb", wb_valid_o, 1);
    check("ror_rd", wb_rd_o, 10);
    check("ror_data", wb_data_o, 32'hDEAD_BEEF);
    check("ror_out0", outstanding_o, 0);
    clr_in(); tick();

    // Reject: no ID consumed.
    put_req(32'h0000_0033, '0);
    check("rej_id", x_issue_id_o, 0);
    put_resp(0, 0);
    check("rej_pulse", rej_valid_o, 1);
    check("rej_word", rej_instr_o, 32'h0000_0033);
    check("rej_out", outstanding_o, 0);
    clr_in(); tick();

    // Fill all IDs, then free id 2 and reuse it.
    for (int k = 0; k < NB; k++) begin
      put_req($urandom, {$urandom, $urandom, $urandom});
      check("full_id", x_issue_id_o, k);
      put_resp(1, 1);
    end
    check("full_ready", req_ready_o, 0);
    put_result(2, 5'd3, 32'h0000_1111, 1);
    check("recycle_ready", req_ready_o, 1);
    put_req(32'h0000_0777, '0);
    check("recycle_id", x_issue_id_o, 2);
    put_resp(1, 0);
    for (int k = 0; k < NB; k++) put_result(k, 5'(k), $urandom, 1);

    // Custom NOP accepted without writeback; second result is for a free ID.
    put_req(32'h0000_007B, '0);
    put_resp(1, 0);
    put_result(0, 5'd7, 32'h5555_AAAA, 1);
    check("nop_no_wb", wb_valid_o, 0);
    put_result(0, 5'd7, 32'h5555_AAAA, 1);
    check("nop_err", err_o, 1);

    // Issue of id 1 coincides with the result for id 0.
    put_req(32'h0000_0100, '0);
    put_resp(1, 1);
    put_req(32'h0000_0200, '0);
    check("sim_id", x_issue_id_o, 1);
    clr_in();
    x_issue_ready_i = 1; x_issue_accept_i = 1; x_issue_writeback_i = 1;
    x_result_valid_i = 1; x_result_id_i = '0; x_result_we_i = 1; x_result_data_i = 32'h0BAD_F00D;
    tick();
    check("sim_out", outstanding_o, 1);
    put_result(1, 5'd1, 32'h1, 1);

    // Accepted issue left without a result (watchdog exercised when enabled).
    put_req(32'h0000_0300, '0);
    put_resp(1, 1);
    clr_in();
    for (int k = 0; k < TO + 4; k++) tick();
    put_result(0, 5'd2, 32'h2, 1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      clr_in();
      req_valid_i = 1'($urandom_range(0, 1));
      req_instr_i = $urandom;
      req_rs_i    = {$urandom, $urandom, $urandom};
      if (m_pend) begin
        x_issue_ready_i     = 1'($urandom_range(0, 1));
        x_issue_accept_i    = ($urandom_range(0, 3) != 0);
        x_issue_writeback_i = 1'($urandom_range(0, 1));
      end
      x_result_valid_i = ($urandom_range(0, 2) == 0);
      x_result_id_i    = IDW'($urandom_range(0, NB - 1));
      x_result_rd_i    = 5'($urandom);
      x_result_data_i  = $urandom;
      x_result_we_i    = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset while an issue is pending.
    clr_in();
    for (int k = 0; k < NB; k++) if (!m_pend) begin
      if (exp_ready()) put_req(32'h0000_0400, '0);
      else put_result(k, 5'd0, 32'h0, 0);
    end
    clr_in();
    #2 rst_ni = 0;
    #1 model_reset();
    check("rst_issue_valid", x_issue_valid_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_ni = 1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
